fsk_demod_word: RTL and testbench
=================================

Name: fsk_demod_word

Overview:
- Receive-side counterpart of the FSK modulator.
- Takes the comparator-sliced 1-bit FSK line, classifies each carrier period as mark or space, and recovers asynchronous frames of 32 data bits.
- Each good frame's word is presented to the HPS-facing 32-bit PIO input (signal_0_export) with a one-cycle valid strobe.
- Sits in fabric between the line-input pin and the soc_system PIO.

Parameters:
- BIT_CLKS, 5000, clocks per bit period (50 MHz / 10 kbaud).
- THRESH, 750, period threshold in clocks: period < THRESH is mark ('1'), otherwise space ('0').
- TIMEOUT, 4000, clocks without a rising edge before the carrier is declared lost.
- PER_W, 16, period and bit counter width; counters saturate at 2^PER_W-1.

Ports:
- clk_clk  input  1  system clock, 50 MHz.
- reset_reset_n  input  1  asynchronous active-low reset.
- fsk_in  input  1  sliced FSK line, asynchronous to clk_clk.
- word_out  output  32  last good received word; LSB is the first data bit received.
- word_valid  output  1  one-cycle pulse when word_out updates.
- frame_err  output  1  one-cycle pulse on bad stop bit (or parity error, see Optional Feature).
- carrier_ok  output  1  high while edges arrive within TIMEOUT.
- busy  output  1  high in states START, DATA, STOP (and PAR when compiled in).

Behaviour:
- Reset values:
  - word_out=0, word_valid=0, frame_err=0, carrier_ok=0, busy=0.
  - FSM=IDLE, tone=1, counters=0.
- Input synchronisation:
  - fsk_in passes through a 2-FF synchronizer plus one edge register.
  - A rising edge is flagged 3 cycles after it appears at the pin.
- Period counter:
  - Increments every cycle and saturates.
  - On a rising edge: tone <= (per_cnt < THRESH); carrier_ok <= 1; per_cnt <= 1.
  - If per_cnt reaches TIMEOUT: carrier_ok <= 0 and tone <= 1 (idle mark).
  - The first edge after reset or after carrier loss only restarts per_cnt; tone is not updated on it.
- Frame format: start bit (space), 32 data bits LSB first, stop bit (mark).
- FSM states:
  - IDLE: busy=0. When tone==0 and carrier_ok, clear bit_cnt and go to START.
  - START: count BIT_CLKS/2 clocks (integer divide).
    - At that point, if tone==0: clear bit_cnt, set bit_idx=0, go to DATA.
    - Otherwise (glitch): return to IDLE silently, no pulse.
  - DATA:
    - Each time bit_cnt reaches BIT_CLKS-1: sample tone into shreg[bit_idx], reset bit_cnt.
    - After bit_idx 31 is sampled, go to STOP.
  - STOP: after BIT_CLKS clocks, sample tone.
    - If 1: word_out <= shreg, word_valid=1 for exactly one cycle.
    - If 0: frame_err=1 for one cycle, word_out unchanged.
    - Either way, next state is IDLE.
- Carrier loss:
  - Losing carrier_ok in any non-IDLE state aborts to IDLE next cycle.
  - No word_valid and no frame_err; shreg is discarded.
- Back-to-back frames:
  - IDLE may detect the next start bit on the cycle after STOP completes.
  - No mandatory idle gap.
- word_valid and frame_err are never high in the same cycle.
- word_out holds its value between frames and is only changed on word_valid.
- Asynchronous reset mid-frame returns everything to reset values immediately; the partial frame is lost.

Optional Feature:
- Macro: FSK_PARITY_EN.
- Defined:
  - Adds state PAR between DATA and STOP.
  - One even-parity bit is sampled after bit 31.
  - If XOR(shreg, parity bit) != 0, frame_err pulses at the STOP sample instead of word_valid, even when the stop bit is good.
  - Frame length is 35 bit periods.
- Undefined:
  - No PAR state; frame length is 34 bit periods.
  - frame_err reflects only the stop bit.

Test Plan:
- Defaults, 1 ms mark idle (500-clk periods), then frame 0xA5C3_0F81 with space=1000-clk periods -> word_valid pulses once ~34*5000 clks after start edge, word_out=0xA5C30F81, frame_err stays 0.
- Same frame but stop bit sent as space -> frame_err pulse once, word_valid 0, word_out keeps previous value (0 after reset).
- Space tone for only 2000 clks (shorter than BIT_CLKS/2) then mark -> FSM returns to IDLE, busy drops, no pulses.
- Carrier stops (fsk_in held 0) at data bit 10 -> carrier_ok falls 4000 clks after last edge, FSM to IDLE, no pulses; next full frame 0x0000_0001 received correctly.
- Two frames 0xFFFF_FFFF and 0x1234_5678 with zero idle gap -> two word_valid pulses, word_out=0x12345678 at end.
- FSK_PARITY_EN defined, frame 0x0000_0003 with parity bit 1 -> frame_err pulse, no word_valid; with parity bit 0 -> word_valid, word_out=0x00000003.

Source files
------------

// File: rtl/fsk_demod_word.sv
// -----------------------------------------------------------------------------
// fsk_demod_word
//   Receive-side FSK demodulator. The comparator-sliced line is synchronised,
//   each carrier period is measured and classified as mark (short period, '1')
//   or space (long period, '0'), and asynchronous frames of
//   start(space) + 32 data bits LSB first + stop(mark) are recovered.
//   A good frame updates word_out together with a one-cycle word_valid pulse;
//   a bad stop bit gives a one-cycle frame_err pulse instead.
//
//   Optional build macro: FSK_PARITY_EN
//     When defined, one even-parity bit follows data bit 31 (PAR state) and a
//     parity mismatch turns an otherwise good frame into a frame_err.
//
// Ports
//   clk_clk        in   1   system clock (50 MHz)
//   reset_reset_n  in   1   asynchronous active-low reset
//   fsk_in         in   1   sliced FSK line, asynchronous to clk_clk
//   word_out       out  32  last good word, LSB = first data bit received
//   word_valid     out  1   one-cycle pulse when word_out updates
//   frame_err      out  1   one-cycle pulse on bad stop (or parity) bit
//   carrier_ok     out  1   high while rising edges arrive within TIMEOUT
//   busy           out  1   high while a frame is being received
// -----------------------------------------------------------------------------
module fsk_demod_word #(
    parameter int BIT_CLKS = 5000,
    parameter int THRESH   = 750,
    parameter int TIMEOUT  = 4000,
    parameter int PER_W    = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        fsk_in,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        frame_err,
    output logic        carrier_ok,
    output logic        busy
);

    localparam logic [PER_W-1:0] C_CNT_MAX   = {PER_W{1'b1}};
    localparam logic [PER_W-1:0] C_THRESH    = PER_W'(THRESH);
    localparam logic [PER_W-1:0] C_TIMEOUT   = PER_W'(TIMEOUT);
    localparam logic [PER_W-1:0] C_BIT_LAST  = PER_W'(BIT_CLKS - 1);
    localparam logic [PER_W-1:0] C_HALF_LAST = PER_W'(BIT_CLKS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef FSK_PARITY_EN
        , S_PAR
`endif
    } state_t;

    // Saturating increment shared by the period and bit counters.
    function automatic logic [PER_W-1:0] f_sat_inc(input logic [PER_W-1:0] v);
        return (v == C_CNT_MAX) ? v : v + PER_W'(1);
    endfunction

`ifdef FSK_PARITY_EN
    // Even parity over data plus parity bit: 1 means the frame is corrupt.
    function automatic logic f_par_err(input logic [31:0] w, input logic p);
        return ^{w, p};
    endfunction
`endif

    // Synchroniser, edge detector and period measurement
    logic             r_sync1;
    logic             r_sync2;
    logic             r_edge;
    logic             r_rise;
    logic [PER_W-1:0] r_per_cnt;
    logic             r_tone;
    logic             r_carrier_ok;

    // FSM and frame datapath
    state_t           r_state;
    state_t           w_state_nxt;
    logic [PER_W-1:0] r_bit_cnt;
    logic [4:0]       r_bit_idx;
    logic [31:0]      r_shreg;
    logic [31:0]      r_word_out;
    logic             r_word_valid;
    logic             r_frame_err;
    logic             r_busy;
    logic             w_bit_done;
    logic             w_cnt_clr;
    logic             w_stop_sample;
    logic             w_frame_good;
`ifdef FSK_PARITY_EN
    logic             r_par_bit;
`endif

    assign word_out   = r_word_out;
    assign word_valid = r_word_valid;
    assign frame_err  = r_frame_err;
    assign carrier_ok = r_carrier_ok;
    assign busy       = r_busy;

    // Two-flop synchroniser plus an edge register; the rise flag is itself
    // registered so an edge is acted on three clocks after it hits the pin.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= fsk_in;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
            r_rise  <= r_sync2 & ~r_edge;
        end
    end

    // Period counter, tone classification and carrier supervision.
    // The first edge after reset or carrier loss has no valid reference
    // period, so it only restarts the counter and re-arms carrier_ok.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_per_cnt    <= '0;
            r_tone       <= 1'b1;
            r_carrier_ok <= 1'b0;
        end else if (r_rise) begin
            r_per_cnt    <= PER_W'(1);
            r_carrier_ok <= 1'b1;
            if (r_carrier_ok) begin
                r_tone <= (r_per_cnt < C_THRESH);
            end else begin
                r_tone <= r_tone;
            end
        end else begin
            r_per_cnt <= f_sat_inc(r_per_cnt);
            if (r_per_cnt >= C_TIMEOUT) begin
                r_carrier_ok <= 1'b0;
                r_tone       <= 1'b1;
            end else begin
                r_carrier_ok <= r_carrier_ok;
                r_tone       <= r_tone;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle decode of bit timing and frame outcome.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_done    = (r_bit_cnt == C_BIT_LAST);
        w_stop_sample = 1'b0;
`ifdef FSK_PARITY_EN
        w_frame_good  = r_tone & ~f_par_err(r_shreg, r_par_bit);
`else
        w_frame_good  = r_tone;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_tone && r_carrier_ok) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (!r_carrier_ok) begin
                    w_state_nxt = S_IDLE;
                end else if (r_bit_cnt == C_HALF_LAST) begin
                    // Mid start bit: still space means a real start bit.
                    w_state_nxt = r_tone ? S_IDLE : S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (!r_carrier_ok) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_done && (r_bit_idx == 5'd31)) begin
`ifdef FSK_PARITY_EN
                    w_state_nxt = S_PAR;
`else
                    w_state_nxt = S_STOP;
`endif
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef FSK_PARITY_EN
            S_PAR: begin
                if (!r_carrier_ok) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_done) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_PAR;
                end
            end
`endif
            S_STOP: begin
                if (!r_carrier_ok) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_done) begin
                    w_state_nxt   = S_IDLE;
                    w_stop_sample = 1'b1;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Bit counter restarts in IDLE, on every state change and at each
        // bit boundary so every later sample lands mid-bit.
        w_cnt_clr = (r_state == S_IDLE) || (w_state_nxt != r_state) || w_bit_done;
    end

    // Frame datapath: bit timing, data shift, word/pulse outputs and busy.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_bit_cnt    <= '0;
            r_bit_idx    <= 5'd0;
            r_shreg      <= 32'd0;
            r_word_out   <= 32'd0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef FSK_PARITY_EN
            r_par_bit    <= 1'b0;
`endif
        end else begin
            r_bit_cnt    <= w_cnt_clr ? '0 : f_sat_inc(r_bit_cnt);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                S_START: begin
                    r_bit_idx <= 5'd0;
                end
                S_DATA: begin
                    if (r_carrier_ok && w_bit_done) begin
                        r_shreg[r_bit_idx] <= r_tone;
                        r_bit_idx          <= r_bit_idx + 5'd1;
                    end else begin
                        r_bit_idx <= r_bit_idx;
                    end
                end
`ifdef FSK_PARITY_EN
                S_PAR: begin
                    if (r_carrier_ok && w_bit_done) begin
                        r_par_bit <= r_tone;
                    end else begin
                        r_par_bit <= r_par_bit;
                    end
                end
`endif
                S_STOP: begin
                    if (w_stop_sample && w_frame_good) begin
                        r_word_out   <= r_shreg;
                        r_word_valid <= 1'b1;
                    end else if (w_stop_sample) begin
                        r_frame_err <= 1'b1;
                    end else begin
                        r_word_out <= r_word_out;
                    end
                end
                default: begin
                    r_bit_idx <= r_bit_idx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_demod_word.sv
// -----------------------------------------------------------------------------
// tb_fsk_demod_word
//   Directed self-checking bench for fsk_demod_word. Timing is scaled down
//   (BIT_CLKS=200, THRESH=30, TIMEOUT=160; mark period 20, space period 40)
//   keeping the ratios of the 50 MHz / 10 kbaud configuration.
//   Build with +define+FSK_PARITY_EN to also exercise the parity bit.
// -----------------------------------------------------------------------------
module tb_fsk_demod_word;

    localparam int BIT     = 200;
    localparam int MARK_P  = 20;
    localparam int SPACE_P = 40;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        fsk   = 1'b0;
    logic [31:0] word_out;
    logic        word_valid;
    logic        frame_err;
    logic        carrier_ok;
    logic        busy;

    int          n_chk   = 0;
    int          n_pass  = 0;
    int          n_valid = 0;
    int          n_err   = 0;
    int          n_both  = 0;
    bit          busy_seen = 1'b0;
    logic [31:0] last_word = 32'd0;
    logic [31:0] prev_word = 32'd0;

    fsk_demod_word #(
        .BIT_CLKS (BIT),
        .THRESH   (30),
        .TIMEOUT  (160),
        .PER_W    (16)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .fsk_in        (fsk),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .frame_err     (frame_err),
        .carrier_ok    (carrier_ok),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles so a stretched pulse is also caught.
    always @(negedge clk) begin
        if (word_valid) begin
            n_valid   = n_valid + 1;
            prev_word = last_word;
            last_word = word_out;
        end
        if (frame_err) n_err = n_err + 1;
        if (word_valid && frame_err) n_both = n_both + 1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic send_period(input int p);
        fsk = 1'b1;
        repeat (p / 2) @(negedge clk);
        fsk = 1'b0;
        repeat (p / 2) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int p;
        p = b ? MARK_P : SPACE_P;
        repeat (BIT / p) send_period(p);
    endtask

    task automatic send_idle(input int nbits);
        repeat (nbits) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic stop_b, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 32; i++) send_bit(w[i]);
`ifdef FSK_PARITY_EN
        send_bit((^w) ^ par_flip);
`endif
        send_bit(stop_b);
    endtask

    initial begin
        logic [31:0] partial;
        partial = 32'h0F0F_0F0F;

        // Reset state
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_word_out",   word_out,           32'd0);
        check_eq("rst_word_valid", 32'(word_valid),    32'd0);
        check_eq("rst_frame_err",  32'(frame_err),     32'd0);
        check_eq("rst_carrier_ok", 32'(carrier_ok),    32'd0);
        check_eq("rst_busy",       32'(busy),          32'd0);

        // Mark idle brings the carrier up without starting a frame
        send_idle(5);
        check_eq("idle_carrier_ok", 32'(carrier_ok), 32'd1);
        check_eq("idle_busy",       32'(busy),       32'd0);

        // Good frame
        send_frame(32'hA5C3_0F81, 1'b1, 1'b0);
        send_idle(2);
        check_eq("good_valid_cnt", 32'(n_valid), 32'd1);
        check_eq("good_err_cnt",   32'(n_err),   32'd0);
        check_eq("good_word",      word_out,     32'hA5C3_0F81);

        // Stop bit sent as space
        send_frame(32'h1111_2222, 1'b0, 1'b0);
        send_idle(2);
        check_eq("badstop_err_cnt",   32'(n_err),   32'd1);
        check_eq("badstop_valid_cnt", 32'(n_valid), 32'd1);
        check_eq("badstop_word_hold", word_out,     32'hA5C3_0F81);

        // Short space burst (less than half a bit) is rejected silently
        busy_seen = 1'b0;
        repeat (2) send_period(SPACE_P);
        send_idle(2);
        check_eq("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check_eq("glitch_busy",      32'(busy),      32'd0);
        check_eq("glitch_valid_cnt", 32'(n_valid),   32'd1);
        check_eq("glitch_err_cnt",   32'(n_err),     32'd1);

        // Carrier vanishes during data bit 10
        send_bit(1'b0);
        for (int i = 0; i < 10; i++) send_bit(partial[i]);
        fsk = 1'b0;
        repeat (300) @(negedge clk);
        check_eq("loss_carrier_ok", 32'(carrier_ok), 32'd0);
        check_eq("loss_busy",       32'(busy),       32'd0);
        check_eq("loss_valid_cnt",  32'(n_valid),    32'd1);
        check_eq("loss_err_cnt",    32'(n_err),      32'd1);
        send_idle(3);
        send_frame(32'h0000_0001, 1'b1, 1'b0);
        send_idle(2);
        check_eq("recover_valid_cnt", 32'(n_valid), 32'd2);
        check_eq("recover_word",      word_out,     32'h0000_0001);

        // Back-to-back frames, no idle gap
        send_frame(32'hFFFF_FFFF, 1'b1, 1'b0);
        send_frame(32'h1234_5678, 1'b1, 1'b0);
        send_idle(2);
        check_eq("b2b_valid_cnt", 32'(n_valid), 32'd4);
        check_eq("b2b_first",     prev_word,    32'hFFFF_FFFF);
        check_eq("b2b_word",      word_out,     32'h1234_5678);
        check_eq("b2b_err_cnt",   32'(n_err),   32'd1);

`ifdef FSK_PARITY_EN
        // Parity bit 1 on 0x3 (even parity wants 0) -> frame error
        send_frame(32'h0000_0003, 1'b1, 1'b1);
        send_idle(2);
        check_eq("par_bad_err_cnt",   32'(n_err),   32'd2);
        check_eq("par_bad_valid_cnt", 32'(n_valid), 32'd4);
        check_eq("par_bad_word_hold", word_out,     32'h1234_5678);
        send_frame(32'h0000_0003, 1'b1, 1'b0);
        send_idle(2);
        check_eq("par_good_valid_cnt", 32'(n_valid), 32'd5);
        check_eq("par_good_word",      word_out,     32'h0000_0003);
`endif

        check_eq("never_both_pulses", 32'(n_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
